// File: rtl/sprite_draw_scheduler.sv
// Frame sequencer that shares one sprite blitter: background first, then every snapshotted
// valid slot in ascending order, with start/done handshake, overrun counting and a watchdog.
module sprite_draw_scheduler #(
    parameter int              NUM_SLOTS    = 6,
    parameter int              ID_W         = 5,
    parameter int              X_W          = 9,
    parameter int              Y_W          = 8,
    parameter logic [ID_W-1:0] BG_ID        = 5'b01000,
    parameter int              WAIT_TIMEOUT = 200000
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic                      frame_tick,
    input  logic [NUM_SLOTS-1:0]      slot_valid,
    input  logic [NUM_SLOTS*ID_W-1:0] slot_id,
    input  logic [NUM_SLOTS*X_W-1:0]  slot_x,
    input  logic [NUM_SLOTS*Y_W-1:0]  slot_y,
    output logic                      blit_start,
    output logic [ID_W-1:0]           blit_id,
    output logic [X_W-1:0]            blit_x,
    output logic [Y_W-1:0]            blit_y,
    input  logic                      blit_busy,
    input  logic                      blit_done,
    output logic                      frame_busy,
    output logic                      frame_done,
    output logic [7:0]                overrun_count,
    output logic                      timeout_err
);
    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);
    // The counter reaches WAIT_TIMEOUT-1 on the edge that ends the final watchdog cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIMEOUT - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                    r_state;
    logic [NUM_SLOTS-1:0]      r_pending;
    logic [NUM_SLOTS*ID_W-1:0] r_snap_id;
    logic [NUM_SLOTS*X_W-1:0]  r_snap_x;
    logic [NUM_SLOTS*Y_W-1:0]  r_snap_y;
    logic [ID_W-1:0]           r_blit_id;
    logic [X_W-1:0]            r_blit_x;
    logic [Y_W-1:0]            r_blit_y;
    logic [CNT_W-1:0]          r_wait_cnt;
    logic                      r_frame_busy;
    logic                      r_frame_done;
    logic [7:0]                r_overrun;
    logic                      r_timeout_err;

    logic [IDX_W:0]            w_pick;
    logic                      w_found;
    logic [IDX_W-1:0]          w_idx;
    logic                      w_timeout;
    logic                      w_req_end;

    // Returns {found, index} of the lowest set bit of the pending mask.
    function automatic logic [IDX_W:0] f_lowest_pending(input logic [NUM_SLOTS-1:0] pend);
        logic [IDX_W:0] res;
        res = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (pend[i]) begin
                res = {1'b1, IDX_W'(i)};
            end
        end
        return res;
    endfunction

    assign w_pick    = f_lowest_pending(r_pending);
    assign w_found   = w_pick[IDX_W];
    assign w_idx     = w_pick[IDX_W-1:0];
    assign w_timeout = (r_wait_cnt == CNT_LAST);
    assign w_req_end = blit_done || w_timeout;

    assign blit_start    = (r_state == S_ISSUE) && !blit_busy;
    assign blit_id       = r_blit_id;
    assign blit_x        = r_blit_x;
    assign blit_y        = r_blit_y;
    assign frame_busy    = r_frame_busy;
    assign frame_done    = r_frame_done;
    assign overrun_count = r_overrun;
    assign timeout_err   = r_timeout_err;

    // Frame sequencing FSM with snapshot, watchdog and overrun bookkeeping.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pending     <= '0;
            r_snap_id     <= '0;
            r_snap_x      <= '0;
            r_snap_y      <= '0;
            r_blit_id     <= '0;
            r_blit_x      <= '0;
            r_blit_y      <= '0;
            r_wait_cnt    <= '0;
            r_frame_busy  <= 1'b0;
            r_frame_done  <= 1'b0;
            r_overrun     <= 8'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (frame_tick && r_frame_busy && (r_overrun != 8'hFF)) begin
                r_overrun <= r_overrun + 8'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (frame_tick) begin
                        r_pending    <= slot_valid;
                        r_snap_id    <= slot_id;
                        r_snap_x     <= slot_x;
                        r_snap_y     <= slot_y;
                        r_blit_id    <= BG_ID;
                        r_blit_x     <= '0;
                        r_blit_y     <= '0;
                        r_frame_busy <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!blit_busy) begin
                        r_wait_cnt <= '0;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    if (w_req_end) begin
                        if (!blit_done) begin
                            r_timeout_err <= 1'b1;
                        end
                        if (w_found) begin
                            r_blit_id          <= r_snap_id[w_idx*ID_W +: ID_W];
                            r_blit_x           <= r_snap_x[w_idx*X_W +: X_W];
                            r_blit_y           <= r_snap_y[w_idx*Y_W +: Y_W];
                            r_pending[w_idx]   <= 1'b0;
                            r_state            <= S_ISSUE;
                        end else begin
                            r_frame_busy <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_state      <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Self-checking bench for sprite_draw_scheduler: table-driven frames, random frames against a
// queue/arithmetic reference, watchdog, busy hold, async reset and overrun saturation.
module tb_sprite_draw_scheduler;
    localparam logic [4:0] BG   = 5'b01000;
    localparam int         LAT_B = 50;

    typedef struct {
        logic [5:0]  v;
        logic [29:0] ids;
        logic [53:0] xs;
        logic [47:0] ys;
        int          lat;
        int          hold;
        bit          skip;
        int          exp_starts;
        int          exp_delay;
        string       name;
    } vec_t;

    typedef struct {
        logic [4:0] id;
        logic [8:0] x;
        logic [7:0] y;
    } blit_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic [5:0]  slot_valid = '0;
    logic [29:0] slot_id = '0;
    logic [53:0] slot_x = '0;
    logic [47:0] slot_y = '0;
    logic        blit_busy = 1'b0;
    logic        blit_busy_b = 1'b0;
    logic        blit_done_a = 1'b0;
    logic        blit_done_b = 1'b0;
    logic        blit_start_a, blit_start_b;
    logic [4:0]  blit_id_a, blit_id_b;
    logic [8:0]  blit_x_a, blit_x_b;
    logic [7:0]  blit_y_a, blit_y_b;
    logic        frame_busy_a, frame_busy_b, frame_done_a, frame_done_b;
    logic [7:0]  overrun_a, overrun_b;
    logic        timeout_err_a, timeout_err_b;

    int cyc = 0;
    int due_a = -1;
    int due_b = -1;
    int lat_a = 10;
    bit skip_mode = 1'b0;
    int checks = 0;
    int failures = 0;

    sprite_draw_scheduler #(.WAIT_TIMEOUT(20)) dut_a (
        .CLOCK_50(clk), .reset(reset), .frame_tick(frame_tick),
        .slot_valid(slot_valid), .slot_id(slot_id), .slot_x(slot_x), .slot_y(slot_y),
        .blit_start(blit_start_a), .blit_id(blit_id_a), .blit_x(blit_x_a), .blit_y(blit_y_a),
        .blit_busy(blit_busy), .blit_done(blit_done_a),
        .frame_busy(frame_busy_a), .frame_done(frame_done_a),
        .overrun_count(overrun_a), .timeout_err(timeout_err_a));

    sprite_draw_scheduler dut_b (
        .CLOCK_50(clk), .reset(reset), .frame_tick(frame_tick),
        .slot_valid(slot_valid), .slot_id(slot_id), .slot_x(slot_x), .slot_y(slot_y),
        .blit_start(blit_start_b), .blit_id(blit_id_b), .blit_x(blit_x_b), .blit_y(blit_y_b),
        .blit_busy(blit_busy_b), .blit_done(blit_done_b),
        .frame_busy(frame_busy_b), .frame_done(frame_done_b),
        .overrun_count(overrun_b), .timeout_err(timeout_err_b));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Blitter models: ack a fixed latency after each start; id 31 is never acked in skip mode.
    always @(negedge clk) begin
        if (reset) begin
            due_a = -1;
            due_b = -1;
        end else begin
            if (blit_start_a) due_a = (skip_mode && blit_id_a == 5'd31) ? -1 : cyc + lat_a;
            if (blit_start_b) due_b = cyc + LAT_B;
        end
    end

    always @(posedge clk) begin
        #1;
        blit_done_a = (cyc == due_a);
        blit_done_b = (cyc == due_b);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t vc);
        blit_t q[$];
        blit_t e;
        int    t, n_st, busy_n, first, to_start, err_cyc, done_cyc;
        bit    got, prev_start;
        @(posedge clk); #1;
        slot_valid = vc.v; slot_id = vc.ids; slot_x = vc.xs; slot_y = vc.ys;
        lat_a = vc.lat; skip_mode = vc.skip; blit_busy = (vc.hold > 0);
        e.id = BG; e.x = 9'd0; e.y = 8'd0;
        q.push_back(e);
        for (int i = 0; i < 6; i++) begin
            if (vc.v[i]) begin
                e.id = vc.ids[i*5 +: 5]; e.x = vc.xs[i*9 +: 9]; e.y = vc.ys[i*8 +: 8];
                q.push_back(e);
            end
        end
        frame_tick = 1'b1;
        t = cyc;
        @(negedge clk);
        check({vc.name, "_busy_at_tick"}, frame_busy_a, 0);
        @(posedge clk); #1;
        frame_tick = 1'b0;
        // Scramble slot inputs mid-frame; drawn values must come from the snapshot.
        slot_valid = 6'($urandom()); slot_id = 30'($urandom());
        slot_x = 54'({$urandom(), $urandom()}); slot_y = 48'({$urandom(), $urandom()});
        n_st = 0; busy_n = 0; first = -1; to_start = -1; err_cyc = -1; done_cyc = -1;
        got = 1'b0; prev_start = 1'b0;
        for (int k = 0; k < 3000 && !got; k++) begin
            if (cyc > t + vc.hold) blit_busy = 1'b0;
            @(negedge clk);
            if (frame_busy_a) busy_n++;
            if (blit_start_a) begin
                n_st++;
                if (first < 0) first = cyc;
                if (blit_id_a == 5'd31) to_start = cyc;
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check({vc.name, "_blit_id"}, blit_id_a, e.id);
                    check({vc.name, "_blit_x"}, blit_x_a, e.x);
                    check({vc.name, "_blit_y"}, blit_y_a, e.y);
                end
                check({vc.name, "_start_width"}, prev_start, 0);
            end
            prev_start = blit_start_a;
            if (timeout_err_a && err_cyc < 0) err_cyc = cyc;
            if (frame_done_a) begin
                got = 1'b1;
                done_cyc = cyc;
            end
            if (!got) begin
                @(posedge clk); #1;
            end
        end
        check({vc.name, "_frame_done_seen"}, got, 1);
        check({vc.name, "_starts"}, n_st, vc.exp_starts);
        check({vc.name, "_done_delay"}, done_cyc - t, vc.exp_delay);
        check({vc.name, "_busy_span"}, busy_n, vc.exp_delay - 1);
        check({vc.name, "_queue_left"}, q.size(), 0);
        check({vc.name, "_timeout_err"}, timeout_err_a, vc.skip);
        if (vc.hold > 0) check({vc.name, "_start_after_busy"}, first - t, vc.hold + 1);
        if (vc.skip) check({vc.name, "_timeout_latency"}, err_cyc - to_start, 20);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; frame_tick = 1'b0; blit_busy = 1'b0; skip_mode = 1'b0;
        repeat (12) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic overrun_run(input int n_cycles, input int period, input string name);
        int drops, idle_from, acc, starts;
        do_reset();
        slot_valid = 6'd0;
        drops = 0; idle_from = 0; acc = 0; starts = 0;
        for (int k = 0; k < n_cycles; k++) begin
            @(posedge clk); #1;
            frame_tick = ((k % period) == 0);
            if (frame_tick) begin
                if (k >= idle_from) begin
                    acc++;
                    idle_from = k + (LAT_B + 1) + 1;
                end else begin
                    drops++;
                end
            end
            @(negedge clk);
            if (blit_start_b) starts++;
        end
        @(posedge clk); #1 frame_tick = 1'b0;
        repeat (120) begin
            @(negedge clk);
            if (blit_start_b) starts++;
        end
        check({name, "_overrun_count"}, overrun_b, (drops > 255) ? 255 : drops);
        check({name, "_frames_started"}, starts, acc);
        check({name, "_idle_after"}, frame_busy_b, 0);
    endtask

    vec_t vecs[6];
    vec_t rv;

    initial begin
        int n;
        vecs[0] = '{6'b000101, {5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd2},
                    {9'd0, 9'd0, 9'd0, 9'd64, 9'd0, 9'd40}, {8'd0, 8'd0, 8'd0, 8'd104, 8'd0, 8'd7},
                    10, 0, 1'b0, 3, 34, "two_slots"};
        vecs[1] = '{6'b000000, 30'h2AAAAAAA, 54'h15, 48'h77, 10, 0, 1'b0, 1, 12, "bg_only"};
        vecs[2] = '{6'b111111, {5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1},
                    {9'd319, 9'd250, 9'd200, 9'd150, 9'd100, 9'd1},
                    {8'd239, 8'd200, 8'd150, 8'd100, 8'd50, 8'd0}, 3, 0, 1'b0, 7, 29, "all_slots"};
        vecs[3] = '{6'b100010, {5'd17, 5'd0, 5'd0, 5'd0, 5'd9, 5'd0},
                    {9'd300, 9'd0, 9'd0, 9'd0, 9'd12, 9'd0}, {8'd220, 8'd0, 8'd0, 8'd0, 8'd33, 8'd0},
                    1, 0, 1'b0, 3, 7, "sparse_fast"};
        vecs[4] = '{6'b000010, {5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0},
                    {9'd0, 9'd0, 9'd0, 9'd0, 9'd100, 9'd0}, {8'd0, 8'd0, 8'd0, 8'd0, 8'd50, 8'd0},
                    4, 30, 1'b0, 2, 41, "busy_hold"};
        vecs[5] = '{6'b000111, {5'd0, 5'd0, 5'd0, 5'd2, 5'd31, 5'd1},
                    {9'd0, 9'd0, 9'd0, 9'd30, 9'd20, 9'd10}, {8'd0, 8'd0, 8'd0, 8'd3, 8'd2, 8'd1},
                    5, 0, 1'b1, 4, 39, "watchdog"};

        #7;
        check("rst_blit_start", blit_start_a, 0);
        check("rst_blit_id", blit_id_a, 0);
        check("rst_frame_busy", frame_busy_a, 0);
        check("rst_overrun", overrun_a, 0);
        check("rst_timeout_err", timeout_err_a, 0);
        @(posedge clk); #1 reset = 1'b0;

        for (int i = 0; i < 6; i++) run_frame(vecs[i]);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            rv.v = 6'($urandom()); rv.ids = 30'($urandom());
            rv.xs = 54'({$urandom(), $urandom()}); rv.ys = 48'({$urandom(), $urandom()});
            rv.lat = $urandom_range(1, 15); rv.hold = 0; rv.skip = 1'b0;
            rv.exp_starts = 1 + $countones(rv.v);
            rv.exp_delay = rv.exp_starts * (rv.lat + 1) + 1;
            rv.name = "random";
            run_frame(rv);
        end

        // Reset asserted while the slot-1 blit is in flight.
        @(posedge clk); #1;
        slot_valid = 6'b000011; slot_id = {5'd0, 5'd0, 5'd0, 5'd0, 5'd9, 5'd3};
        slot_x = {9'd0, 9'd0, 9'd0, 9'd0, 9'd77, 9'd5}; slot_y = {8'd0, 8'd0, 8'd0, 8'd0, 8'd66, 8'd4};
        lat_a = 10; skip_mode = 1'b0;
        frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        n = 0;
        for (int k = 0; k < 200 && n < 3; k++) begin
            @(negedge clk);
            if (blit_start_a) n++;
        end
        check("midwait_reached_slot1", n, 3);
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_rst_blit_start", blit_start_a, 0);
        check("async_rst_blit_id", blit_id_a, 0);
        check("async_rst_blit_x", blit_x_a, 0);
        check("async_rst_blit_y", blit_y_a, 0);
        check("async_rst_frame_busy", frame_busy_a, 0);
        check("async_rst_frame_done", frame_done_a, 0);
        check("async_rst_overrun", overrun_a, 0);
        check("async_rst_timeout", timeout_err_a, 0);
        repeat (12) @(posedge clk);
        #1 reset = 1'b0;
        vecs[1].name = "after_reset";
        run_frame(vecs[1]);

        overrun_run(300, 5, "tick_every_5");
        overrun_run(300, 1, "saturate");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
